// File: rtl/mux21_2b_rr_arbiter.sv
// Round-robin arbiter feeding the 2:1 2-bit mux: registers the winning word and its select.
// Optional grant counters are built when ARB_GRANT_CNT_EN is defined.
module mux21_2b_rr_arbiter #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ready_a,
    input  logic             valid_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ready_b,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             sel_out,
`ifdef ARB_GRANT_CNT_EN
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
`endif
    input  logic             ready_out
);

    logic prio;
    logic load;
    logic grant_a;
    logic grant_b;

    // Register is free when empty or being drained in this same cycle.
    assign load    = !valid_out || ready_out;
    assign grant_a = !reset && load && valid_a && (!valid_b || !prio);
    assign grant_b = !reset && load && valid_b && (!valid_a ||  prio);
    assign ready_a = grant_a;
    assign ready_b = grant_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sel_out   <= 1'b0;
            prio      <= 1'b0;
        end else if (load) begin
            if (grant_a) begin
                valid_out <= 1'b1;
                data_out  <= data_a;
                sel_out   <= 1'b0;
                prio      <= 1'b1;
            end else if (grant_b) begin
                valid_out <= 1'b1;
                data_out  <= data_b;
                sel_out   <= 1'b1;
                prio      <= 1'b0;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

`ifdef ARB_GRANT_CNT_EN
    // Saturating counters: stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (grant_a && cnt_a != '1) cnt_a <= cnt_a + 1'b1;
            if (grant_b && cnt_b != '1) cnt_b <= cnt_b + 1'b1;
        end
    end
`endif

endmodule
